uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
UART 8N1 receiver: the receive-side counterpart of the team's single-byte serial transmitter.
- Oversamples the asynchronous RxIn line and validates the start bit at mid-bit.
- Shifts in 8 data bits LSB first and checks the stop bit.
- Presents the byte on a level Ready / Ack handshake, with framing-error and overrun reporting.
- Sits between the board RX pin and the byte consumer, e.g. the SHA-256 message loader.

Parameters:
OVERSAMPLE, 16, Clk cycles per serial bit; must be even and >= 4.
CNT_W, $clog2(OVERSAMPLE), oversample counter width; derived, not overridden.

Ports:
Clk  in  1  clock, OVERSAMPLE x bit rate
Reset  in  1  asynchronous, active-low
RxIn  in  1  asynchronous serial input; idle high
DataOut  out  8  received byte; valid while Ready=1
Ready  out  1  byte-available level; held until Ack
Ack  in  1  consumer acknowledge; single-cycle pulse or level
FrameErr  out  1  one-cycle pulse when the stop bit is sampled low
Overrun  out  1  sticky; a byte completed while Ready=1; cleared by Ack

Behaviour:
- Reset is asynchronous, active-low; clock is Clk.
- Reset values:
  - DataOut=0, Ready=0, FrameErr=0, Overrun=0.
  - Both synchronizer flops = 1.
  - state=IDLE, counters=0.
- Frame format:
  - Start bit = 0.
  - Data bits d0..d7, LSB first.
  - Stop bit = 1.
  - No parity.
- Synchronizer: 2 flops on RxIn. rxs is the second flop. Its latency is 2 cycles and is excluded from the timings below.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - On rxs==0: clear the oversample counter and go to START.
  - Call this cycle t0.
- START:
  - At t0+OVERSAMPLE/2, sample rxs.
  - rxs==1: glitch/false start; return to IDLE, no output.
  - rxs==0: clear counters and go to DATA.
- DATA:
  - Bit i (0..7) is sampled at t0+OVERSAMPLE/2+(i+1)*OVERSAMPLE.
  - Shift: shreg <= {rxs, shreg[7:1]}.
  - After bit 7, go to STOP.
- STOP: sampled at t0+OVERSAMPLE/2+9*OVERSAMPLE (t0+152 for OVERSAMPLE=16).
  - rxs==1: deliver the byte in the next cycle (t0+153), then go to IDLE.
  - rxs==0: pulse FrameErr for 1 cycle, discard the byte (DataOut and Ready unchanged), go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs==1, then go to IDLE. This prevents a held-low line (break) from retriggering start detection.
- Delivery:
  - Ready==0, or Ack==1 in the same cycle: DataOut<=shreg, Ready<=1.
  - Ready==1 and Ack==0: DataOut unchanged (the older byte is kept), Overrun<=1.
- Ack:
  - Ack==1 with no coincident delivery: Ready<=0, Overrun<=0.
  - Ack==1 with coincident delivery: new byte loaded, Ready stays 1, Overrun<=0.
  - Ack while Ready==0: no effect.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge right after the stop bit is caught. Tolerates roughly ±(OVERSAMPLE/2-1)/(9.5*OVERSAMPLE) baud mismatch.
- Reset mid-frame: the partial byte is lost; all outputs return to reset values. The first frame starts only after rxs is seen high then low.
- Counters saturate at nothing: the oversample counter wraps modulo OVERSAMPLE; the bit counter is 3 bits, 0..7.

Decomposition:
- Shared package uart_pkg:
  - DATA_BITS=8, START_LVL=1'b0, STOP_LVL=1'b1, IDLE_LVL=1'b1.
  - FSM state encoding for uart_rx_byte.
  - Reused by the transmit-side blocks.
- One sub-module: uart_rx_sync, a 2-flop synchronizer with async active-low reset to 1. Everything else stays in uart_rx_byte.

Test Plan:
- Nominal receive:
  - Stimulus: frame 0xA5 at 16 Clk/bit, Ack low.
  - Response: Ready rises at t0+153 with DataOut=8'hA5; FrameErr=0 and Overrun=0 throughout.
- Glitch rejection:
  - Stimulus: RxIn low for 4 cycles, then high.
  - Response: FSM returns to IDLE; no Ready, no FrameErr.
  - Follow-up: a frame 0x5A 20 cycles later is received as 0x5A.
- Framing error:
  - Stimulus: frame 0x3C with stop bit 0, line held low 40 more cycles, then frame 0x81.
  - Response: one FrameErr pulse at t0+152; Ready stays 0 during the error; 0x81 is then delivered correctly.
- Overrun:
  - Stimulus: back-to-back frames 0x11 and 0x22, Ack never asserted.
  - Response: DataOut=0x11, Ready=1, and Overrun=1 after the second stop bit.
  - Follow-up: a 1-cycle Ack gives Ready=0 and Overrun=0.
- Coincident Ack:
  - Stimulus: Ack pulsed exactly in the delivery cycle of frame 0x22 while 0x11 is pending.
  - Response: DataOut=0x22, Ready stays 1, Overrun=0.
- Reset mid-frame:
  - Stimulus: Reset asserted low after data bit 3 of 0xF0, released, then a full frame 0x0F.
  - Response: all outputs at reset values immediately; only 0x0F is delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame width and the receiver FSM encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input; resets to the idle (high) level.
module uart_rx_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability filter for the asynchronous line
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver with mid-bit sampling, Ready/Ack byte handshake,
// framing-error pulse and sticky overrun flag.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter  int OVERSAMPLE = 16,
    localparam int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       RxIn,
    output logic [7:0] DataOut,
    output logic       Ready,
    input  logic       Ack,
    output logic       FrameErr,
    output logic       Overrun
);

    localparam logic [CNT_W-1:0]     HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]     FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    logic                   w_rxs;
    logic [CNT_W-1:0]       w_os_next;
    rx_state_e              r_state;
    logic [CNT_W-1:0]       r_os_cnt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shreg;
    logic                   r_deliver;
    logic                   r_frame_err;
    logic [DATA_BITS-1:0]   r_data_out;
    logic                   r_ready;
    logic                   r_overrun;

    uart_rx_sync u_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .i_d   (RxIn),
        .o_q   (w_rxs)
    );

    // OVERSAMPLE need not be a power of two, so wrap explicitly
    assign w_os_next = (r_os_cnt == FULL_M1) ? {CNT_W{1'b0}} : r_os_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Frame FSM: start validation, data shift-in and stop check
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_os_cnt    <= {CNT_W{1'b0}};
            r_bit_cnt   <= {BIT_CNT_W{1'b0}};
            r_shreg     <= {DATA_BITS{1'b0}};
            r_deliver   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_deliver   <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_os_cnt <= {CNT_W{1'b0}};
                    if (w_rxs == START_LVL) begin
                        r_state <= ST_START;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (r_os_cnt == HALF_M1) begin
                        r_os_cnt  <= {CNT_W{1'b0}};
                        r_bit_cnt <= {BIT_CNT_W{1'b0}};
                        r_state   <= (w_rxs == START_LVL) ? ST_DATA : ST_IDLE;
                    end else begin
                        r_os_cnt <= w_os_next;
                    end
                end
                ST_DATA: begin
                    r_os_cnt <= w_os_next;
                    if (r_os_cnt == FULL_M1) begin
                        r_shreg   <= {w_rxs, r_shreg[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_STOP: begin
                    r_os_cnt <= w_os_next;
                    if (r_os_cnt == FULL_M1) begin
                        // Leaving here mid-stop-bit lets the next start edge be caught
                        if (w_rxs == STOP_LVL) begin
                            r_deliver <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    r_os_cnt <= {CNT_W{1'b0}};
                    if (w_rxs == IDLE_LVL) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_IDLE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_os_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Consumer handshake: a pending byte is never overwritten without Ack
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_data_out <= 8'h00;
            r_ready    <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (r_deliver) begin
            if (!r_ready || Ack) begin
                r_data_out <= r_shreg;
                r_ready    <= 1'b1;
                r_overrun  <= 1'b0;
            end else begin
                r_overrun  <= 1'b1;
            end
        end else if (Ack) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ready   <= r_ready;
            r_overrun <= r_overrun;
        end
    end

    assign DataOut  = r_data_out;
    assign Ready    = r_ready;
    assign Overrun  = r_overrun;
    assign FrameErr = r_frame_err;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus random frames
// checked against a frame-level model of the Ready/Ack/Overrun rules.
module tb_uart_rx_byte;

    localparam int OS    = 16;
    localparam int FRAME = 10 * OS;
    // Drive at negedge c=0 -> two sync stages -> FSM t0 three edges later; Ready at t0+153
    localparam int RDY_C = 156;
    localparam int FE_C  = 155;

    logic       Clk;
    logic       Reset;
    logic       RxIn;
    logic [7:0] DataOut;
    logic       Ready;
    logic       Ack;
    logic       FrameErr;
    logic       Overrun;

    int n_checks;
    int n_fail;

    logic [7:0] exp_data;
    logic       exp_ready;
    logic       exp_ovr;

    logic [7:0] data_tr [0:FRAME-1];
    logic       rdy_tr  [0:FRAME-1];
    logic       ovr_tr  [0:FRAME-1];
    int         fe_cnt;
    int         fe_first;

    uart_rx_byte #(.OVERSAMPLE(OS)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .RxIn     (RxIn),
        .DataOut  (DataOut),
        .Ready    (Ready),
        .Ack      (Ack),
        .FrameErr (FrameErr),
        .Overrun  (Overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Sends one 10-bit frame, recording outputs at every negedge before driving
    task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at);
        logic [9:0] bits;
        bits     = {stop, b, 1'b0};
        fe_cnt   = 0;
        fe_first = -1;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge Clk);
            data_tr[c] = DataOut;
            rdy_tr[c]  = Ready;
            ovr_tr[c]  = Overrun;
            if (FrameErr === 1'b1) begin
                if (fe_cnt == 0) fe_first = c;
                fe_cnt++;
            end
            RxIn = bits[c / OS];
            Ack  = (c == ack_at) ? 1'b1 : 1'b0;
        end
        Ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            RxIn = 1'b1;
        end
    endtask

    task automatic pulse_ack();
        @(negedge Clk);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        exp_ready = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    // Frame-level consumer model: what a completed good frame does to the outputs
    task automatic model_deliver(input logic [7:0] b, input logic ack);
        if (!exp_ready || ack) begin
            exp_data  = b;
            exp_ready = 1'b1;
        end else begin
            exp_ovr = 1'b1;
        end
        if (ack) exp_ovr = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        RxIn  = 1'b1;
        Ack   = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++; if (DataOut !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", DataOut); end
        n_checks++; if (Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", Ready); end
        n_checks++; if (FrameErr !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b expected 0", FrameErr); end
        n_checks++; if (Overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", Overrun); end
        Reset = 1'b1;
        exp_data = 8'h00; exp_ready = 1'b0; exp_ovr = 1'b0;
        idle(5);
    endtask

    task automatic test_nominal();
        int bad_ovr;
        send_frame(8'hA5, 1'b1, -1);
        model_deliver(8'hA5, 1'b0);
        bad_ovr = 0;
        for (int c = 0; c < FRAME; c++) if (ovr_tr[c] !== 1'b0) bad_ovr++;
        n_checks++; if (rdy_tr[RDY_C-1] !== 1'b0) begin n_fail++; $display("FAIL nominal_ready_early: got %b expected 0", rdy_tr[RDY_C-1]); end
        n_checks++; if (rdy_tr[RDY_C] !== 1'b1) begin n_fail++; $display("FAIL nominal_ready_rise: got %b expected 1", rdy_tr[RDY_C]); end
        n_checks++; if (data_tr[RDY_C] !== exp_data) begin n_fail++; $display("FAIL nominal_data: got %h expected %h", data_tr[RDY_C], exp_data); end
        n_checks++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL nominal_fe: got %0d pulses expected 0", fe_cnt); end
        n_checks++; if (bad_ovr !== 0) begin n_fail++; $display("FAIL nominal_ovr: got %0d cycles high expected 0", bad_ovr); end
        pulse_ack();
        n_checks++; if (Ready !== exp_ready) begin n_fail++; $display("FAIL nominal_ack: got %b expected %b", Ready, exp_ready); end
        idle(4);
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge Clk);
            if (Ready !== 1'b0 || FrameErr !== 1'b0) bad++;
            RxIn = (c < 4) ? 1'b0 : 1'b1;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL glitch_no_output: got %0d bad cycles expected 0", bad); end
        send_frame(8'h5A, 1'b1, -1);
        model_deliver(8'h5A, 1'b0);
        n_checks++; if (data_tr[RDY_C] !== exp_data || rdy_tr[RDY_C] !== 1'b1) begin
            n_fail++; $display("FAIL glitch_followup: got %h/%b expected %h/1", data_tr[RDY_C], rdy_tr[RDY_C], exp_data);
        end
        pulse_ack();
        idle(4);
    endtask

    task automatic test_frame_err();
        int bad;
        send_frame(8'h3C, 1'b0, -1);
        n_checks++; if (fe_cnt !== 1 || fe_first !== FE_C) begin
            n_fail++; $display("FAIL framerr_pulse: got %0d pulses at %0d expected 1 at %0d", fe_cnt, fe_first, FE_C);
        end
        bad = 0;
        for (int c = 0; c < FRAME; c++) if (rdy_tr[c] !== 1'b0) bad++;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (Ready !== 1'b0 || FrameErr !== 1'b0 || DataOut !== exp_data) bad++;
            RxIn = 1'b0;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL framerr_quiet: got %0d bad cycles expected 0", bad); end
        idle(OS);
        send_frame(8'h81, 1'b1, -1);
        model_deliver(8'h81, 1'b0);
        n_checks++; if (data_tr[RDY_C] !== exp_data || rdy_tr[RDY_C] !== 1'b1 || fe_cnt !== 0) begin
            n_fail++; $display("FAIL framerr_recover: got %h/%b fe=%0d expected %h/1 fe=0", data_tr[RDY_C], rdy_tr[RDY_C], fe_cnt, exp_data);
        end
        pulse_ack();
        idle(4);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, -1);
        model_deliver(8'h11, 1'b0);
        send_frame(8'h22, 1'b1, -1);
        model_deliver(8'h22, 1'b0);
        n_checks++; if (ovr_tr[RDY_C-1] !== 1'b0 || ovr_tr[RDY_C] !== exp_ovr) begin
            n_fail++; $display("FAIL overrun_set: got %b->%b expected 0->%b", ovr_tr[RDY_C-1], ovr_tr[RDY_C], exp_ovr);
        end
        n_checks++; if (data_tr[FRAME-1] !== exp_data || rdy_tr[FRAME-1] !== exp_ready) begin
            n_fail++; $display("FAIL overrun_keep: got %h/%b expected %h/%b", data_tr[FRAME-1], rdy_tr[FRAME-1], exp_data, exp_ready);
        end
        pulse_ack();
        n_checks++; if (Ready !== exp_ready || Overrun !== exp_ovr) begin
            n_fail++; $display("FAIL overrun_ack: got %b/%b expected %b/%b", Ready, Overrun, exp_ready, exp_ovr);
        end
        idle(4);
    endtask

    task automatic test_coincident_ack();
        int bad;
        send_frame(8'h11, 1'b1, -1);
        model_deliver(8'h11, 1'b0);
        send_frame(8'h22, 1'b1, FE_C);
        model_deliver(8'h22, 1'b1);
        bad = 0;
        for (int c = RDY_C; c < FRAME; c++) begin
            if (data_tr[c] !== exp_data || rdy_tr[c] !== exp_ready || ovr_tr[c] !== exp_ovr) bad++;
        end
        n_checks++; if (bad !== 0) begin
            n_fail++; $display("FAIL coincident_ack: got %h/%b/%b expected %h/%b/%b", data_tr[RDY_C], rdy_tr[RDY_C], ovr_tr[RDY_C], exp_data, exp_ready, exp_ovr);
        end
        pulse_ack();
        idle(4);
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        send_frame(8'h77, 1'b1, -1);
        bits = {1'b1, 8'hF0, 1'b0};
        for (int c = 0; c < 5 * OS; c++) begin
            @(negedge Clk);
            RxIn = bits[c / OS];
        end
        @(negedge Clk);
        Reset = 1'b0;
        RxIn  = 1'b1;
        #1;
        exp_data = 8'h00; exp_ready = 1'b0; exp_ovr = 1'b0;
        n_checks++; if (DataOut !== exp_data || Ready !== exp_ready || Overrun !== exp_ovr || FrameErr !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h/%b/%b/%b expected 00/0/0/0", DataOut, Ready, Overrun, FrameErr);
        end
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        idle(10);
        send_frame(8'h0F, 1'b1, -1);
        model_deliver(8'h0F, 1'b0);
        n_checks++; if (rdy_tr[RDY_C-1] !== 1'b0 || rdy_tr[RDY_C] !== 1'b1 || data_tr[RDY_C] !== exp_data) begin
            n_fail++; $display("FAIL midreset_followup: got %b->%b %h expected 0->1 %h", rdy_tr[RDY_C-1], rdy_tr[RDY_C], data_tr[RDY_C], exp_data);
        end
        pulse_ack();
        idle(4);
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         mode;
        for (int k = 0; k < 10; k++) begin
            b    = 8'($urandom_range(0, 255));
            mode = int'($urandom_range(0, 2));
            send_frame(b, 1'b1, (mode == 1) ? FE_C : -1);
            model_deliver(b, (mode == 1) ? 1'b1 : 1'b0);
            n_checks++; if (data_tr[FRAME-1] !== exp_data || rdy_tr[FRAME-1] !== exp_ready || ovr_tr[FRAME-1] !== exp_ovr || fe_cnt !== 0) begin
                n_fail++; $display("FAIL random_%0d: got %h/%b/%b fe=%0d expected %h/%b/%b fe=0", k, data_tr[FRAME-1], rdy_tr[FRAME-1], ovr_tr[FRAME-1], fe_cnt, exp_data, exp_ready, exp_ovr);
            end
            if (mode == 2) begin
                pulse_ack();
                n_checks++; if (Ready !== exp_ready || Overrun !== exp_ovr) begin
                    n_fail++; $display("FAIL random_ack_%0d: got %b/%b expected %b/%b", k, Ready, Overrun, exp_ready, exp_ovr);
                end
            end
            idle(int'($urandom_range(0, 20)));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_nominal();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_coincident_ack();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
